press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 5_000_000, which is the hold length for a long press (1 s at 200 ns CLK).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1_500_000, which is the double-press window (300 ms).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 23, which is the timer width and SHALL hold max(LONG_CYCLES, GAP_CYCLES).
REQ-004 The block SHALL have port CLK, input, 1 bit: system clock, 200 ns period, rising-edge active.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port detected, input, 1 bit: debounced switch level from switch_detect, synchronous to CLK, high = pressed.
REQ-007 The block SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short press.
REQ-008 The block SHALL have port long_press, output, 1 bit: one-cycle pulse for a held press.
REQ-009 The block SHALL have port double_press, output, 1 bit: one-cycle pulse for two presses within the gap window.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL register detected once into det_d; press edge = detected & !det_d; release edge = !detected & det_d.
REQ-012 The block SHALL implement the states IDLE, PRESS1, HOLD, GAP and PRESS2, held in a single state register.
REQ-013 In IDLE, a press edge SHALL move the state to PRESS1 and clear the timer; other inputs are ignored.
REQ-014 In PRESS1, the timer SHALL count sampled high cycles, with the edge sample counting as 1.
REQ-015 In PRESS1, reaching LONG_CYCLES consecutive high samples SHALL assert long_press for one cycle, starting after that edge, and move the state to HOLD.
REQ-016 In PRESS1, a release edge before LONG_CYCLES SHALL move the state to GAP and clear the timer.
REQ-017 In HOLD, a release edge SHALL move the state to IDLE with no output pulse.
REQ-018 In GAP, the timer SHALL count low samples, with the release sample counting as 1.
REQ-019 In GAP, a press edge while the count is below GAP_CYCLES SHALL move the state to PRESS2.
REQ-020 In GAP, reaching GAP_CYCLES low samples SHALL assert short_press for one cycle and move the state to IDLE.
REQ-021 In PRESS2, a release edge SHALL assert double_press for one cycle and move the state to IDLE, regardless of press duration.
REQ-022 The press, long and double outputs SHALL be registered, mutually exclusive, and never high for two consecutive cycles.
REQ-023 The timer SHALL stop at its threshold and never wrap.
REQ-024 Once the timer reaches GAP_CYCLES, a press edge in that same cycle SHALL yield short_press, and the press SHALL be ignored until the next IDLE edge.

Reset
REQ-025 When RST is low, the state SHALL be IDLE, the timer 0, all outputs 0 and det_d 1, asynchronously.
REQ-026 Because det_d resets to 1, a switch held at reset release SHALL NOT register as a press.
REQ-027 Reset during any state SHALL abort the classification with no pulse emitted.

Configuration
REQ-028 With macro PRESS_COUNT_EN defined, the block SHALL add output press_count[7:0]: an 8-bit count of press edges accepted in IDLE or GAP, reset to 0, saturating at 255.
REQ-029 Without PRESS_COUNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification (LONG_CYCLES=20, GAP_CYCLES=10)
REQ-030 Stimulus: detected high 5 samples, then low. Required response: one short_press at the 10th low sample; no other pulse; busy low afterwards.
REQ-031 Stimulus: detected high 25 samples, then low. Required response: one long_press after the 20th high sample; no short_press or double_press on release.
REQ-032 Stimulus: high 5, low 4, high 5, low. Required response: one double_press at the first low sample after the second press; no short_press.
REQ-033 Stimulus, gap boundary: high 5, low 9, high at the 10th sample. Required response: double_press.
REQ-034 Stimulus, gap boundary: high 5, low 10, high. Required response: short_press only, and the late press is ignored.
REQ-035 Stimulus: RST low mid-PRESS1, then released with detected high. Required response: no pulse, state IDLE, and no press counted until detected goes low and then high.
REQ-036 Stimulus, with PRESS_COUNT_EN: 300 short presses. Required response: press_count = 255.

Source files
------------

// File: rtl/press_classifier.sv
// press_classifier: classifies a debounced switch level into short, long and double presses.
// Optional PRESS_COUNT_EN adds a saturating count of accepted press edges.
module press_classifier #(
    parameter int LONG_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 1_500_000,
    parameter int CNT_WIDTH   = 23
) (
    input  logic CLK,
    input  logic RST,
    input  logic detected,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
`ifdef PRESS_COUNT_EN
    ,output logic [7:0] press_count
`endif
);
    typedef enum logic [2:0] {IDLE, PRESS1, HOLD, GAP, PRESS2} state_t;
    localparam logic [CNT_WIDTH-1:0] L_LONG = CNT_WIDTH'(LONG_CYCLES);
    localparam logic [CNT_WIDTH-1:0] L_GAP  = CNT_WIDTH'(GAP_CYCLES);
    state_t               r_state, w_state;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic                 r_det_d, r_short, r_long, r_double;
    logic                 w_short, w_long, w_double, w_accept;
    logic                 w_press, w_release;
    assign w_press   = detected & ~r_det_d;
    assign w_release = ~detected & r_det_d;
    assign w_cnt_inc = r_cnt + 1'b1;
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_short  = 1'b0;
        w_long   = 1'b0;
        w_double = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: if (w_press) begin
                w_state  = PRESS1;
                w_cnt    = CNT_WIDTH'(1);
                w_accept = 1'b1;
            end
            PRESS1: if (w_release) begin
                w_state = GAP;
                w_cnt   = CNT_WIDTH'(1);
            end else if (w_cnt_inc >= L_LONG) begin
                w_state = HOLD;
                w_long  = 1'b1;
                w_cnt   = '0;
            end else begin
                w_cnt = w_cnt_inc;
            end
            HOLD: if (w_release) w_state = IDLE;
            // A full gap wins over a press edge arriving in the same cycle
            GAP: if (r_cnt >= L_GAP) begin
                w_state = IDLE;
                w_short = 1'b1;
                w_cnt   = '0;
            end else if (w_press) begin
                w_state  = PRESS2;
                w_accept = 1'b1;
            end else begin
                w_cnt = w_cnt_inc;
            end
            PRESS2: if (w_release) begin
                w_state  = IDLE;
                w_double = 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end
    // det_d resets high so a switch held through reset is not seen as a press
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_det_d  <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_det_d  <= detected;
            r_short  <= w_short;
            r_long   <= w_long;
            r_double <= w_double;
        end
    end
    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign busy         = r_state != IDLE;
`ifdef PRESS_COUNT_EN
    logic [7:0] r_press_count;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_press_count <= '0;
        else if (w_accept && r_press_count != 8'hFF) r_press_count <= r_press_count + 1'b1;
    end
    assign press_count = r_press_count;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed checks of press classification with LONG=20, GAP=10.
module tb_press_classifier;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic detected = 1'b0;
    logic short_press, long_press, double_press, busy;
`ifdef PRESS_COUNT_EN
    logic [7:0] press_count;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int n_short = 0, n_long = 0, n_double = 0, n_bad = 0;
    bit prev = 1'b0;

    press_classifier #(.LONG_CYCLES(20), .GAP_CYCLES(10), .CNT_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .detected(detected),
        .short_press(short_press), .long_press(long_press),
        .double_press(double_press), .busy(busy)
`ifdef PRESS_COUNT_EN
        ,.press_count(press_count)
`endif
    );

    always #100 CLK = ~CLK;

    // Pulse monitor samples midway between edges
    always @(posedge CLK) begin
        #50;
        if (short_press) n_short++;
        if (long_press) n_long++;
        if (double_press) n_double++;
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1 ||
            (prev && (short_press || long_press || double_press))) n_bad++;
        prev = short_press | long_press | double_press;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drv(input logic v, input int n);
        repeat (n) begin
            detected = v;
            @(negedge CLK);
        end
    endtask

    task automatic clr();
        n_short = 0;
        n_long = 0;
        n_double = 0;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_busy", int'(busy), 0);
        chk("rst_short", int'(short_press), 0);
        chk("rst_long", int'(long_press), 0);
        chk("rst_double", int'(double_press), 0);
`ifdef PRESS_COUNT_EN
        chk("rst_count", int'(press_count), 0);
`endif
        RST = 1'b1;
        drv(0, 3);

        clr(); drv(1, 5); drv(0, 15);
        chk("short_cnt", n_short, 1);
        chk("short_nolong", n_long, 0);
        chk("short_nodouble", n_double, 0);
        chk("short_busy", int'(busy), 0);

        clr(); drv(1, 19);
        chk("long_early", n_long, 0);
        drv(1, 1);
        chk("long_at20", n_long, 1);
        drv(1, 5);
        chk("long_busy_hold", int'(busy), 1);
        drv(0, 15);
        chk("long_total", n_long, 1);
        chk("long_noshort", n_short, 0);
        chk("long_nodouble", n_double, 0);
        chk("long_busy", int'(busy), 0);

        clr(); drv(1, 5); drv(0, 4); drv(1, 5); drv(0, 1);
        chk("dbl_first_low", n_double, 1);
        drv(0, 15);
        chk("dbl_noshort", n_short, 0);
        chk("dbl_total", n_double, 1);
        chk("dbl_busy", int'(busy), 0);

        clr(); drv(1, 5); drv(0, 9); drv(1, 3); drv(0, 15);
        chk("gap9_double", n_double, 1);
        chk("gap9_noshort", n_short, 0);

        clr(); drv(1, 5); drv(0, 10); drv(1, 2);
        chk("gap10_busy", int'(busy), 0);
        drv(1, 3); drv(0, 15);
        chk("gap10_short", n_short, 1);
        chk("gap10_nodouble", n_double, 0);
        chk("gap10_nolong", n_long, 0);

        clr(); drv(1, 3);
        RST = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        drv(1, 2);
        RST = 1'b1;
        drv(1, 5);
        chk("rst_rel_busy", int'(busy), 0);
        chk("rst_rel_pulses", n_short + n_long + n_double, 0);
        drv(0, 2); drv(1, 3);
        chk("rst_repress_busy", int'(busy), 1);
        drv(0, 15);
        chk("rst_repress_short", n_short, 1);
        chk("pulse_excl", n_bad, 0);

`ifdef PRESS_COUNT_EN
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        drv(0, 2);
        repeat (3) begin drv(1, 2); drv(0, 12); end
        chk("count_3", int'(press_count), 3);
        repeat (297) begin drv(1, 2); drv(0, 12); end
        chk("count_sat", int'(press_count), 255);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
